// File: rtl/multiple_of_3_detector.sv
// Serial MSB-first divisibility-by-3 detector: out=1 while the value absorbed since reset is a multiple of 3.
// Optional MUL3_REM_OUT_EN exposes the running remainder on port rem.
//
// state | meaning
// ------+------------------------------------------
// S0    | accumulated value mod 3 == 0 (also after reset)
// S1    | accumulated value mod 3 == 1
// S2    | accumulated value mod 3 == 2
// S_ILL | unused encoding; recovers to S0 next cycle
module multiple_of_3_detector (
  input  logic       clk,
  input  logic       res,
  input  logic       I,
  output logic       out
`ifdef MUL3_REM_OUT_EN
  ,
  output logic [1:0] rem
`endif
);

  typedef enum logic [1:0] {
    S0    = 2'b00,
    S1    = 2'b01,
    S2    = 2'b10,
    S_ILL = 2'b11
  } state_t;

  state_t state;
  state_t state_nx;

  always_ff @(posedge clk) begin
    if (res) state <= S0;
    else     state <= state_nx;
  end

  // New remainder is (2*rem + I) mod 3.
  always_comb begin
    state_nx = S0;
    case (state)
      S0:      state_nx = I ? S1 : S0;
      S1:      state_nx = I ? S0 : S2;
      S2:      state_nx = I ? S2 : S1;
      default: state_nx = S0;
    endcase
  end

  assign out = (state == S0);

`ifdef MUL3_REM_OUT_EN
  assign rem = state;
`endif

endmodule

// File: tb/tb_multiple_of_3_detector.sv
// Self-checking bench for multiple_of_3_detector: arithmetic reference model checked every cycle,
// directed literal streams, exhaustive 8-bit sweep and randomized stimulus with occasional resets.
module tb_multiple_of_3_detector;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic I   = 1'b0;
  logic out;
`ifdef MUL3_REM_OUT_EN
  logic [1:0] rem;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: the accumulated value itself, kept as a wide integer reduced mod 3
  // (reduction preserves the residue so the value never overflows).
  longint model_val   = 0;
  bit     model_valid = 1'b0;

  always #5 clk = ~clk;

  multiple_of_3_detector dut (
    .clk (clk),
    .res (res),
    .I   (I),
    .out (out)
`ifdef MUL3_REM_OUT_EN
    ,
    .rem (rem)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (res) begin
      model_val   <= 0;
      model_valid <= 1'b1;
    end else begin
      model_val <= (model_val * 2 + longint'(I)) % 3;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("cycle_out", int'(out), int'(model_val % 3 == 0));
`ifdef MUL3_REM_OUT_EN
      check("cycle_rem", int'(rem), int'(model_val % 3));
`endif
    end
  end

  // One clock: drive at negedge, settle 2 time units past the posedge.
  task automatic cyc(input logic r, input logic b);
    @(negedge clk);
    res = r;
    I   = b;
    @(posedge clk);
    #2;
  endtask

  task automatic run_stream(input string name, input int n, input bit bits[],
                            input bit exp_out[], input int exp_rem[]);
    for (int k = 0; k < n; k++) begin
      cyc(1'b0, bits[k]);
      check({name, "_out"}, int'(out), int'(exp_out[k]));
      check({name, "_model_rem"}, int'(model_val), exp_rem[k]);
    end
  endtask

  initial begin
    bit     sa[]   = '{1,0,1,1,0,1,0,1,0,1};
    bit     sa_o[] = '{0,0,0,0,0,1,1,0,0,0};
    int     sa_r[] = '{1,2,2,2,1,0,0,1,2,2};
    bit     sb[]   = '{0,1,0,1,0,1,0,0,1,0};
    bit     sb_o[] = '{1,0,0,0,0,1,1,1,0,0};
    int     sb_r[] = '{0,1,2,2,1,0,0,0,1,2};
    longint seg_val;
    int     seg_len;
    logic   b;
    logic [7:0] v;

    // Reset then hold
    cyc(1'b1, 1'b1);
    check("reset_out", int'(out), 1);
    cyc(1'b1, 1'b1);
    check("reset_hold_out", int'(out), 1);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0);
      check("zeros_out", int'(out), 1);
    end

    // Short values: 1,1 -> 3 ; 0 -> 6 ; 1 -> 13
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); check("short_1", int'(out), 0);
    cyc(1'b0, 1'b1); check("short_3", int'(out), 1);
    cyc(1'b0, 1'b0); check("short_6", int'(out), 1);
    cyc(1'b0, 1'b1); check("short_13", int'(out), 0);

    // Stream A
    cyc(1'b1, 1'b0);
    run_stream("streamA", 10, sa, sa_o, sa_r);

    // Stream B: reset held 3 cycles
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1);
    check("streamB_reset_out", int'(out), 1);
    run_stream("streamB", 10, sb, sb_o, sb_r);

    // Mid-stream reset
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1); check("mid_1", int'(out), 0);
    cyc(1'b0, 1'b0); check("mid_2", int'(out), 0);
    check("mid_2_model_rem", int'(model_val), 2);
    cyc(1'b1, 1'b1); check("mid_reset", int'(out), 1);
    cyc(1'b0, 1'b1); check("mid_after_1", int'(out), 0);
    cyc(1'b0, 1'b1); check("mid_after_3", int'(out), 1);

    // Exhaustive 8-bit values
    for (int val = 0; val < 256; val++) begin
      v = 8'(val);
      cyc(1'b1, 1'b0);
      for (int k = 7; k >= 0; k--) cyc(1'b0, v[k]);
      check("exh_out", int'(out), int'(val % 3 == 0));
`ifdef MUL3_REM_OUT_EN
      check("exh_rem", int'(rem), val % 3);
`endif
    end

    // Randomized stream with sporadic resets; full value kept for segments up to 60 bits
    cyc(1'b1, 1'b0);
    seg_val = 0;
    seg_len = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 31) == 0) begin
        cyc(1'b1, 1'($urandom_range(0, 1)));
        seg_val = 0;
        seg_len = 0;
        check("rand_reset_out", int'(out), 1);
      end else begin
        b = 1'($urandom_range(0, 1));
        cyc(1'b0, b);
        if (seg_len < 60) begin
          seg_val = seg_val * 2 + longint'(b);
          seg_len++;
          check("rand_fullval_out", int'(out), int'(seg_val % 3 == 0));
        end
      end
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
